// File: rtl/gr_apb_pkg.sv
// Shared types for the APB4 requester: response codes, FSM states and the
// byte-offset width helper used for alignment checks.
package gr_apb_pkg;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    SLVERR   = 2'd1,
    TIMEOUT  = 2'd2,
    MISALIGN = 2'd3
  } rsp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // log2 of the strobe width; 0 for an 8-bit bus (no offset bits to check).
  function automatic int strb_log2(input int strb_w);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < strb_w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gr_apb_master.sv
// APB4 requester: one valid/ready command in, SETUP/ACCESS on the bus, one
// valid/ready response out. Define GR_APB_MASTER_TIMEOUT_EN to bound ACCESS waits.
module gr_apb_master
  import gr_apb_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int STRB_W         = DATA_W / 8  // derived; leave at default
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  input  logic [2:0]        cmd_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_code,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  output logic [2:0]        pprot,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam int OFF_W = strb_log2(STRB_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [2:0]        prot_q, prot_d;
  rsp_e              code_q, code_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef GR_APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      code_q  <= OK;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    code_d  = code_q;
    rdata_d = rdata_q;
`ifdef GR_APB_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          strb_d  = cmd_strb;
          prot_d  = cmd_prot;
          if ((cmd_addr & ALIGN_MASK) != '0) begin
            code_d  = MISALIGN;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef GR_APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          code_d  = pslverr ? SLVERR : OK;
          rdata_d = (write_q || pslverr) ? '0 : prdata;
          state_d = RESP;
        end
`ifdef GR_APB_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          code_d  = TIMEOUT;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        // Clear the status on hand-off so it reads 0 while idle.
        if (rsp_ready) begin
          code_d  = OK;
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic bus_active;
  assign bus_active = (state_q == SETUP) || (state_q == ACCESS);

  assign cmd_ready = (state_q == IDLE);
  assign psel      = bus_active;
  assign penable   = (state_q == ACCESS);
  assign pwrite    = bus_active && write_q;
  assign paddr     = bus_active ? addr_q : '0;
  assign pwdata    = (bus_active && write_q) ? wdata_q : '0;
  assign pstrb     = (bus_active && write_q) ? strb_q : '0;
  assign pprot     = bus_active ? prot_q : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_code  = code_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_gr_apb_master.sv
// Directed bench for gr_apb_master (ADDR_W=64, DATA_W=32, TIMEOUT_CYCLES=4);
// covers the timeout path when GR_APB_MASTER_TIMEOUT_EN is defined.
module tb_gr_apb_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [63:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int checks;
  int errors;

  gr_apb_master #(
    .ADDR_W(64),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code), .rsp_rdata(rsp_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [63:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, psel, penable, pwrite, rsp_valid} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 10000", {cmd_ready, psel, penable, pwrite, rsp_valid});
    end
    checks++;
    if ({paddr, pwdata, pstrb, pprot, rsp_code, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data paddr %h pwdata %h pstrb %h pprot %h code %h rdata %h exp all 0",
               paddr, pwdata, pstrb, pprot, rsp_code, rsp_rdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", cmd_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_write();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
    drive_cmd(1'b1, 64'h40, 32'hDEAD_BEEF, 4'hF, 3'b010);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_accept_ready got %b exp 1", cmd_ready);
    end
    tick();  // T+1
    cmd_valid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, cmd_ready, rsp_valid, paddr, pwdata, pstrb, pprot} !==
        {5'b10100, 64'h40, 32'hDEAD_BEEF, 4'hF, 3'b010}) begin
      errors++;
      $display("FAIL wr_setup ctl %b paddr %h pwdata %h pstrb %h pprot %h exp 10100 40 deadbeef f 2",
               {psel, penable, pwrite, cmd_ready, rsp_valid}, paddr, pwdata, pstrb, pprot);
    end
    tick();  // T+2
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot} !==
        {3'b111, 64'h40, 32'hDEAD_BEEF, 4'hF, 3'b010}) begin
      errors++;
      $display("FAIL wr_access ctl %b paddr %h pwdata %h pstrb %h pprot %h exp 111 40 deadbeef f 2",
               {psel, penable, pwrite}, paddr, pwdata, pstrb, pprot);
    end
    tick();  // T+3
    checks++;
    if ({rsp_valid, rsp_code, rsp_rdata, psel, penable, paddr, pwdata, pstrb} !==
        {1'b1, 2'd0, 32'h0, 2'b00, 64'h0, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL wr_resp valid %b code %0d rdata %h psel %b paddr %h pwdata %h exp 1 0 0 0 0 0",
               rsp_valid, rsp_code, rsp_rdata, psel, paddr, pwdata);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_code, rsp_rdata} !== {1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL wr_resp_hold valid %b code %0d rdata %h exp 1 0 0", rsp_valid, rsp_code, rsp_rdata);
    end
    release_rsp();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_back_idle got %b exp 01", {rsp_valid, cmd_ready});
    end
    $display("test_write done");
  endtask

  task automatic test_read_wait();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    drive_cmd(1'b0, 64'h100, 32'hAAAA_5555, 4'hF, 3'b000);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, pwdata, pstrb} !== {3'b100, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL rd_setup ctl %b pwdata %h pstrb %h exp 100 0 0", {psel, penable, pwrite}, pwdata, pstrb);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({psel, penable, pwrite, rsp_valid, paddr, pwdata, pstrb} !== {4'b1100, 64'h100, 32'h0, 4'h0}) begin
        errors++;
        $display("FAIL rd_access_%0d ctl %b paddr %h pwdata %h pstrb %h exp 1100 100 0 0",
                 i, {psel, penable, pwrite, rsp_valid}, paddr, pwdata, pstrb);
      end
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'h1234_5678;
      end
      tick();
    end
    checks++;
    if ({rsp_valid, psel, rsp_code, rsp_rdata} !== {2'b10, 2'd0, 32'h1234_5678}) begin
      errors++;
      $display("FAIL rd_resp valid %b psel %b code %0d rdata %h exp 1 0 0 12345678",
               rsp_valid, psel, rsp_code, rsp_rdata);
    end
    release_rsp();
    $display("test_read_wait done");
  endtask

  task automatic test_slverr();
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE_F00D;
    drive_cmd(1'b0, 64'h8, 32'h0, 4'h0, 3'b001);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL err_access got %b exp 11", {psel, penable});
    end
    tick();
    checks++;
    if ({rsp_valid, psel, penable, rsp_code, rsp_rdata} !== {3'b100, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL err_resp valid %b psel %b code %0d rdata %h exp 1 0 1 0",
               rsp_valid, psel, rsp_code, rsp_rdata);
    end
    pslverr = 1'b0;
    release_rsp();
    $display("test_slverr done");
  endtask

  task automatic test_misalign();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h5555_AAAA;
    drive_cmd(1'b0, 64'h42, 32'h0, 4'h0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({rsp_valid, psel, penable, cmd_ready, rsp_code, rsp_rdata} !== {4'b1000, 2'd3, 32'h0}) begin
      errors++;
      $display("FAIL mis_resp valid %b psel %b ready %b code %0d rdata %h exp 1 0 0 3 0",
               rsp_valid, psel, cmd_ready, rsp_code, rsp_rdata);
    end
    tick();
    checks++;
    if ({rsp_valid, psel} !== 2'b10) begin
      errors++;
      $display("FAIL mis_hold got %b exp 10", {rsp_valid, psel});
    end
    release_rsp();
    $display("test_misalign done");
  endtask

  task automatic test_timeout();
`ifdef GR_APB_MASTER_TIMEOUT_EN
    int n;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    drive_cmd(1'b0, 64'h200, 32'h0, 4'h0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (penable) n++;
      tick();
    end
    checks++;
    if ({n, rsp_valid, rsp_code, rsp_rdata} !== {32'd4, 1'b1, 2'd2, 32'h0}) begin
      errors++;
      $display("FAIL to_abort access %0d valid %b code %0d rdata %h exp 4 1 2 0", n, rsp_valid, rsp_code, rsp_rdata);
    end
    release_rsp();
    drive_cmd(1'b0, 64'h204, 32'h0, 4'h0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({penable, rsp_valid} !== 2'b10) begin
        errors++;
        $display("FAIL to_late_%0d got %b exp 10", i, {penable, rsp_valid});
      end
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'h0BAD_F00D;
      end
      tick();
    end
    checks++;
    if ({rsp_valid, rsp_code, rsp_rdata} !== {1'b1, 2'd0, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL to_last_wins valid %b code %0d rdata %h exp 1 0 0badf00d", rsp_valid, rsp_code, rsp_rdata);
    end
    release_rsp();
`else
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    drive_cmd(1'b0, 64'h200, 32'h0, 4'h0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    repeat (11) tick();
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL wait_forever got %b exp 110", {psel, penable, rsp_valid});
    end
    pready = 1'b1;
    prdata = 32'h0BAD_F00D;
    tick();
    checks++;
    if ({rsp_valid, rsp_code, rsp_rdata} !== {1'b1, 2'd0, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL wait_complete valid %b code %0d rdata %h exp 1 0 0badf00d", rsp_valid, rsp_code, rsp_rdata);
    end
    release_rsp();
`endif
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    logic seen;
    pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b0;
    drive_cmd(1'b1, 64'h80, 32'h1111_2222, 4'hF, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (penable !== 1'b1) begin
      errors++;
      $display("FAIL rm_in_access got %b exp 1", penable);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL rm_async got %b exp 0010", {psel, penable, cmd_ready, rsp_valid});
    end
    pready = 1'b1;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if ({seen, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rm_no_rsp seen %b ready %b exp 0 1", seen, cmd_ready);
    end
    drive_cmd(1'b1, 64'h44, 32'h0102_0304, 4'h3, 3'b001);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pstrb, pprot} !== {3'b101, 64'h44, 4'h3, 3'b001}) begin
      errors++;
      $display("FAIL rm_fresh_setup ctl %b paddr %h pstrb %h pprot %h exp 101 44 3 1",
               {psel, penable, pwrite}, paddr, pstrb, pprot);
    end
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_code, rsp_rdata} !== {1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL rm_fresh_resp valid %b code %0d rdata %h exp 1 0 0", rsp_valid, rsp_code, rsp_rdata);
    end
    release_rsp();
    $display("test_reset_mid done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gr_apb_master.md
Name: gr_apb_master

Overview:
Parametrised APB4 requester that turns a single-beat valid/ready command stream into compliant SETUP/ACCESS bus phases. It returns status and read data on a valid/ready response stream. It adds PSTRB/PPROT, configurable address/data widths, wait-state handling, alignment checking and an optional access timeout. It sits between register-access sequencer logic and the APB fabric, driving the same APB signal set as the team's APB interface.

Parameters:
ADDR_W, 64, paddr/cmd_addr width
DATA_W, 32, pwdata/prdata width; must be 8, 16, 32 or 64
TIMEOUT_CYCLES, 256, max ACCESS cycles waited for pready (>=1); used only with the timeout macro
STRB_W, DATA_W/8, derived, byte strobe width

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  STRB_W  write byte strobes
cmd_prot  in  3  PPROT value
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_code  out  2  status, per gr_apb_pkg::rsp_e
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
psel, penable, pwrite  out  1 each  APB controls
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  STRB_W  APB strobes
pprot  out  3  APB protection
pready, pslverr  in  1 each  completer handshake/error
prdata  in  DATA_W  completer read data

Behaviour:
- Reset (async assert, sync deassert at the next clk edge): state IDLE. psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_code and rsp_rdata are all 0; cmd_ready=1.
- States:
  - IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
  - IDLE -> RESP directly on misalign.
- IDLE:
  - cmd_ready=1; all other outputs 0.
  - On cmd_valid: register the command.
  - If cmd_addr[log2(STRB_W)-1:0]!=0, go to RESP with code MISALIGN; no bus activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - psel=1, penable=0.
  - paddr, pwrite and pprot driven from the registered command.
  - Writes: pwdata=wdata, pstrb=strb.
  - Reads: pwdata=0, pstrb=0.
- ACCESS:
  - psel=1, penable=1; all address/data/control outputs held stable.
  - Stay in ACCESS while pready=0.
  - On pready=1: capture prdata for reads (0 for writes) and set code = pslverr ? SLVERR : OK. Go to RESP.
- RESP:
  - psel=penable=0; paddr/pwdata/pstrb return to 0.
  - rsp_valid=1; rsp_code/rsp_rdata held stable until rsp_ready.
  - On rsp_ready: go to IDLE.
- cmd_ready is 0 outside IDLE, so only one transaction is in flight.
- Latency: command accepted at cycle T, SETUP at T+1, ACCESS at T+2. With zero wait states, rsp_valid asserts at T+3. Minimum throughput is 4 cycles per transaction.
- Reset mid-transaction:
  - Bus drops immediately (psel=penable=0).
  - The pending response is discarded and never issued.
- pslverr is sampled only when psel&penable&pready.
- prdata on writes is ignored.

Optional Feature:
GR_APB_MASTER_TIMEOUT_EN
- With the macro:
  - A counter of ACCESS cycles with pready=0 clears on entering ACCESS.
  - If pready is still low after TIMEOUT_CYCLES ACCESS cycles, abort: go to RESP with code TIMEOUT and rdata 0.
  - pready=1 in the final counted cycle wins and completes normally.
- Without the macro: no counter; the block waits indefinitely and TIMEOUT is never produced.

Decomposition:
- gr_apb_pkg holds:
  - rsp_e: OK=0, SLVERR=1, TIMEOUT=2, MISALIGN=3.
  - state_e: IDLE, SETUP, ACCESS, RESP.
  - The function computing log2(STRB_W).
- No sub-module. The FSM, command register and timeout counter live in a single module.

Test Plan:
- Write addr 0x40, data 0xDEADBEEF, strb 0xF, prot 3'b010, pready=1 at first ACCESS -> SETUP at T+1 and ACCESS at T+2 with paddr=0x40, pstrb=0xF, pprot=2; rsp_valid at T+3 with code OK, rdata 0.
- Read addr 0x100, pready low for 3 ACCESS cycles then high with prdata=0x12345678 -> 4 ACCESS cycles, all outputs stable; rsp_rdata=0x12345678, code OK.
- Read addr 0x8, pslverr=1 with pready -> code SLVERR, rdata 0; psel low the next cycle.
- Read addr 0x42 (DATA_W=32) -> psel never asserts; rsp_valid 1 cycle after accept, code MISALIGN.
- Macro on, TIMEOUT_CYCLES=4, pready held 0 -> exactly 4 ACCESS cycles, then code TIMEOUT. Repeat with pready=1 in the 4th cycle -> code OK.
- Assert reset during ACCESS with rsp_ready held 0 -> psel/penable/cmd_ready take their reset values immediately; no rsp_valid after reset release. A fresh command then completes normally.
